// File: rtl/zbuffer_mem_responder_if.sv
// Bus bundles around the z-buffer responder: the per-core request/response
// side (cores are master) and the Avalon-MM style memory side (responder is master).

interface zbuf_core_if #(
   parameter int NUM_CORES = 4
);
   logic [NUM_CORES-1:0]           texture_req;
   logic [NUM_CORES-1:0][31:0]     texture_addr;
   logic [NUM_CORES-1:0][6:0]      texture_core_id;
   logic [NUM_CORES-1:0]           texture_valid;
   logic [NUM_CORES-1:0][31:0]     texture_data;
   logic [NUM_CORES-1:0]           texture_read_done;
   logic [NUM_CORES-1:0]           write_req;
   logic [NUM_CORES-1:0][31:0]     write_addr;
   logic [NUM_CORES-1:0][31:0]     write_data;
   logic [NUM_CORES-1:0][6:0]      write_core_id;
   logic [NUM_CORES-1:0]           write_valid;
   logic [NUM_CORES-1:0]           write_done;

   modport master (
      output texture_req, texture_addr, texture_core_id, texture_read_done,
             write_req, write_addr, write_data, write_core_id,
      input  texture_valid, texture_data, write_valid, write_done
   );

   modport slave (
      input  texture_req, texture_addr, texture_core_id, texture_read_done,
             write_req, write_addr, write_data, write_core_id,
      output texture_valid, texture_data, write_valid, write_done
   );
endinterface

interface zbuf_mem_if;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_writedata;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;
   logic        mem_readdatavalid;

   modport master (
      output mem_read, mem_write, mem_address, mem_writedata,
      input  mem_waitrequest, mem_readdata, mem_readdatavalid
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_writedata,
      output mem_waitrequest, mem_readdata, mem_readdatavalid
   );
endinterface

// File: rtl/zbuffer_mem_responder.sv
// Z-buffer memory responder: captures per-core read/write pulses, serialises
// them round-robin onto a single Avalon-MM master, holds read data until the
// core acks and pulses write completion.

// Per-core request slot: pending capture, held read data, errors.
module zbuf_core_slot #(
   parameter int IDX = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_req,
   input  logic [31:0] rd_addr_in,
   input  logic [6:0]  rd_id,
   input  logic        rd_ack,
   input  logic        wr_req,
   input  logic [31:0] wr_addr_in,
   input  logic [31:0] wr_data_in,
   input  logic [6:0]  wr_id,
   input  logic        rd_clr,
   input  logic        wr_clr,
   input  logic        rd_load,
   input  logic [31:0] load_data,
   output logic        rd_pend,
   output logic        wr_pend,
   output logic [31:0] rd_addr,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        tex_valid,
   output logic [31:0] tex_data,
   output logic        wr_pulse,
   output logic        err_proto,
   output logic        err_id
);
   localparam logic [6:0] ID = 7'(IDX);

   logic rd_busy, wr_busy, rd_take, wr_take;

   // A pend being released this very cycle counts as free, so a back-to-back
   // pulse from the core being served is captured rather than flagged.
   assign rd_busy = (rd_pend & ~rd_clr) | tex_valid;
   assign wr_busy = wr_pend & ~wr_clr;
   assign rd_take = rd_req & ~rd_busy;
   assign wr_take = wr_req & ~wr_busy;

   // Capture new requests and release them once memory accepts them
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend <= 1'b0;
         wr_pend <= 1'b0;
         rd_addr <= '0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         if (rd_take) begin
            rd_pend <= 1'b1;
            rd_addr <= rd_addr_in;
         end else if (rd_clr) begin
            rd_pend <= 1'b0;
         end
         if (wr_take) begin
            wr_pend <= 1'b1;
            wr_addr <= wr_addr_in;
            wr_data <= wr_data_in;
         end else if (wr_clr) begin
            wr_pend <= 1'b0;
         end
      end
   end

   // Hold read data until ack, pulse write completion, latch sticky errors
   always_ff @(posedge clk) begin
      if (rst) begin
         tex_valid <= 1'b0;
         tex_data  <= '0;
         wr_pulse  <= 1'b0;
         err_proto <= 1'b0;
         err_id    <= 1'b0;
      end else begin
         if (rd_load) begin
            tex_valid <= 1'b1;
            tex_data  <= load_data;
         end else if (rd_ack) begin
            tex_valid <= 1'b0;
         end
         wr_pulse <= wr_clr;
         if ((rd_req & rd_busy) | (wr_req & wr_busy))
            err_proto <= 1'b1;
         if ((rd_take && rd_id != ID) || (wr_take && wr_id != ID))
            err_id <= 1'b1;
      end
   end
endmodule

module zbuffer_mem_responder #(
   parameter int          NUM_CORES = 4,
   parameter logic [31:0] ZBUF_BASE = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   zbuf_core_if.slave           core,
   zbuf_mem_if.master           mem,
   output logic [NUM_CORES-1:0] err_proto,
   output logic [NUM_CORES-1:0] err_id
);
   localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} state_t;

   state_t                     state, state_nxt;
   logic [IW-1:0]              rr_ptr, gnt_q, gnt_idx, cand;
   logic                       gnt_found, gnt_rd;
   logic [31:0]                addr_q, wdata_q, sel_addr;
   logic [NUM_CORES-1:0]       rd_pend, wr_pend, rd_elig, tex_valid, wr_pulse;
   logic [NUM_CORES-1:0]       rd_clr, wr_clr, rd_load;
   logic [NUM_CORES-1:0][31:0] rd_addr, wr_addr, wr_data, tex_data;

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
      zbuf_core_slot #(.IDX(i)) u_slot (
         .clk        (clk),
         .rst        (rst),
         .rd_req     (core.texture_req[i]),
         .rd_addr_in (core.texture_addr[i]),
         .rd_id      (core.texture_core_id[i]),
         .rd_ack     (core.texture_read_done[i]),
         .wr_req     (core.write_req[i]),
         .wr_addr_in (core.write_addr[i]),
         .wr_data_in (core.write_data[i]),
         .wr_id      (core.write_core_id[i]),
         .rd_clr     (rd_clr[i]),
         .wr_clr     (wr_clr[i]),
         .rd_load    (rd_load[i]),
         .load_data  (mem.mem_readdata),
         .rd_pend    (rd_pend[i]),
         .wr_pend    (wr_pend[i]),
         .rd_addr    (rd_addr[i]),
         .wr_addr    (wr_addr[i]),
         .wr_data    (wr_data[i]),
         .tex_valid  (tex_valid[i]),
         .tex_data   (tex_data[i]),
         .wr_pulse   (wr_pulse[i]),
         .err_proto  (err_proto[i]),
         .err_id     (err_id[i])
      );
   end

   assign core.texture_valid = tex_valid;
   assign core.texture_data  = tex_data;
   assign core.write_valid   = wr_pulse;
   assign core.write_done    = wr_pulse;

   assign mem.mem_read      = (state == RD_ISSUE);
   assign mem.mem_write     = (state == WR_ISSUE);
   assign mem.mem_address   = addr_q;
   assign mem.mem_writedata = wdata_q;

   // A read stays parked while the core still holds unacked data.
   assign rd_elig = rd_pend & ~tex_valid;

   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_CORES) s = s - NUM_CORES;
      return IW'(s);
   endfunction

   // Round-robin scan from rr_ptr; within the winner a read beats a write
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      gnt_rd    = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         cand = rr_idx(rr_ptr, k);
         if (!gnt_found && (rd_elig[cand] || wr_pend[cand])) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
            gnt_rd    = rd_elig[cand];
         end
      end
      sel_addr = gnt_rd ? rd_addr[gnt_idx] : wr_addr[gnt_idx];
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next state and per-core release/load strobes
   always_comb begin
      state_nxt = state;
      rd_clr    = '0;
      wr_clr    = '0;
      rd_load   = '0;
      case (state)
         IDLE:
            if (gnt_found) state_nxt = gnt_rd ? RD_ISSUE : WR_ISSUE;
         RD_ISSUE:
            if (!mem.mem_waitrequest) begin
               rd_clr[gnt_q] = 1'b1;
               state_nxt     = RD_WAIT;
            end
         RD_WAIT:
            if (mem.mem_readdatavalid) begin
               rd_load[gnt_q] = 1'b1;
               state_nxt      = IDLE;
            end
         WR_ISSUE:
            if (!mem.mem_waitrequest) begin
               wr_clr[gnt_q] = 1'b1;
               state_nxt     = IDLE;
            end
         default: state_nxt = IDLE;
      endcase
   end

   // Register the grant: winner, advanced pointer, byte address and write data
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr  <= '0;
         gnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (state == IDLE && gnt_found) begin
         gnt_q   <= gnt_idx;
         rr_ptr  <= (gnt_idx == IW'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
         // Word-to-byte shift drops the top two address bits; sum wraps mod 2^32.
         addr_q  <= ZBUF_BASE + (sel_addr << 2);
         if (!gnt_rd) wdata_q <= wr_data[gnt_idx];
      end
   end
endmodule
